// File: rtl/cell_frame_capture.sv
// rtl/cell_frame_capture.sv - packed 24-bpp AXI4-Stream line receiver producing one-bit cell rows
// Optional build macro CELL_CAPTURE_COLOUR_MATCH_EN: live only on the exact live colour CB416B.
module cell_frame_capture #(
  parameter int X_SIZE = 1280,
  parameter int Y_SIZE = 720,
  localparam int X_WIDTH = $clog2(X_SIZE),
  localparam int Y_WIDTH = $clog2(Y_SIZE),
  localparam int WORDS   = X_SIZE * 3 / 4
) (
  input  logic               in_stream_aclk,
  input  logic               periph_reset,
  input  logic [31:0]        in_stream_tdata,
  input  logic [3:0]         in_stream_tkeep,
  input  logic               in_stream_tlast,
  input  logic               in_stream_tuser,
  input  logic               in_stream_tvalid,
  output logic               in_stream_tready,
  output logic [X_SIZE-1:0]  line_wdata,
  output logic [Y_WIDTH-1:0] line_waddr,
  output logic               line_we,
  output logic               frame_done,
  output logic               sync_err,
  input  logic               err_clr
);

  typedef enum logic [1:0] {SEEK_SOF, CAPTURE, COMMIT} state_t;

  localparam logic [X_WIDTH-1:0] LAST_W = X_WIDTH'(WORDS - 1);
  localparam logic [Y_WIDTH-1:0] LAST_Y = Y_WIDTH'(Y_SIZE - 1);

  state_t             state, state_next;
  logic [X_WIDTH-1:0] w;
  logic [Y_WIDTH-1:0] y;
  logic [1:0]         phase, ph_eff, phase_next;
  logic [15:0]        carry, carry_next;
  logic [X_SIZE-1:0]  row_sr, row_next;
  logic               hs, take, first, err, drop, y_clr;
  logic               live_a, live_b;
  logic [7:0]         b0, b1, b2, b3;
  logic               unused_tkeep;

  assign unused_tkeep = ^in_stream_tkeep;
  assign hs = in_stream_tvalid & in_stream_tready;
  assign b0 = in_stream_tdata[7:0];
  assign b1 = in_stream_tdata[15:8];
  assign b2 = in_stream_tdata[23:16];
  assign b3 = in_stream_tdata[31:24];

  function automatic logic is_live(input logic [23:0] px);
`ifdef CELL_CAPTURE_COLOUR_MATCH_EN
    return px == 24'hCB416B;
`else
    return |px;
`endif
  endfunction

  // A beat restarting a row is unpacked as word 0 regardless of the running phase.
  assign ph_eff = first ? 2'd0 : phase;

  always_comb begin
    live_a     = 1'b0;
    live_b     = 1'b0;
    carry_next = carry;
    row_next   = {row_sr[X_SIZE-2:0], 1'b0};
    phase_next = 2'd0;
    case (ph_eff)
      2'd0: begin
        live_a     = is_live({b0, b1, b2});
        carry_next = {carry[15:8], b3};
        row_next   = {row_sr[X_SIZE-2:0], live_a};
        phase_next = 2'd1;
      end
      2'd1: begin
        live_a     = is_live({carry[7:0], b0, b1});
        carry_next = {b3, b2};
        row_next   = {row_sr[X_SIZE-2:0], live_a};
        phase_next = 2'd2;
      end
      default: begin
        live_a     = is_live({carry[7:0], carry[15:8], b0});
        live_b     = is_live({b1, b2, b3});
        row_next   = {row_sr[X_SIZE-3:0], live_a, live_b};
        phase_next = 2'd0;
      end
    endcase
  end

  always_comb begin
    state_next = state;
    take       = 1'b0;
    first      = 1'b0;
    err        = 1'b0;
    drop       = 1'b0;
    y_clr      = 1'b0;
    case (state)
      SEEK_SOF: begin
        if (hs && in_stream_tuser) begin
          take       = 1'b1;
          first      = 1'b1;
          y_clr      = 1'b1;
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        if (hs) begin
          if (in_stream_tuser && (w != '0 || y != '0)) begin
            // Misplaced SOF: realign to row 0 and keep this beat as its first word.
            err   = 1'b1;
            take  = 1'b1;
            first = 1'b1;
            y_clr = 1'b1;
          end else if (!in_stream_tuser && w == '0 && y == '0) begin
            err        = 1'b1;
            drop       = 1'b1;
            state_next = SEEK_SOF;
          end else if (in_stream_tlast != (w == LAST_W)) begin
            err        = 1'b1;
            drop       = 1'b1;
            state_next = SEEK_SOF;
          end else begin
            take = 1'b1;
            if (in_stream_tlast) state_next = COMMIT;
          end
        end
      end
      COMMIT:  state_next = (y == LAST_Y) ? SEEK_SOF : CAPTURE;
      default: state_next = SEEK_SOF;
    endcase
  end

  assign line_we    = (state == COMMIT);
  assign frame_done = (state == COMMIT) && (y == LAST_Y);

  always_ff @(posedge in_stream_aclk or posedge periph_reset) begin
    if (periph_reset) begin
      state            <= SEEK_SOF;
      in_stream_tready <= 1'b0;
      sync_err         <= 1'b0;
      line_wdata       <= '0;
      line_waddr       <= '0;
      w                <= '0;
      y                <= '0;
      phase            <= 2'd0;
      carry            <= '0;
      row_sr           <= '0;
    end else begin
      state            <= state_next;
      in_stream_tready <= (state_next != COMMIT);
      if (err)          sync_err <= 1'b1;
      else if (err_clr) sync_err <= 1'b0;
      if (take) begin
        row_sr <= row_next;
        carry  <= carry_next;
        phase  <= phase_next;
        if (state_next == COMMIT) begin
          w          <= '0;
          line_wdata <= row_next;
          line_waddr <= y;
        end else if (first) begin
          w <= X_WIDTH'(1);
        end else begin
          w <= w + X_WIDTH'(1);
        end
      end
      if (drop) begin
        w     <= '0;
        phase <= 2'd0;
      end
      if (y_clr)                 y <= '0;
      else if (state == COMMIT)  y <= (y == LAST_Y) ? '0 : y + Y_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_cell_frame_capture.sv
// tb/tb_cell_frame_capture.sv - scoreboard bench for cell_frame_capture on a reduced 16x8 frame
// Row writes are predicted into a queue and matched by an independent monitor.
module tb_cell_frame_capture;
  localparam int XS    = 16;
  localparam int YS    = 8;
  localparam int YW    = $clog2(YS);
  localparam int WORDS = XS * 3 / 4;

  typedef struct packed {
    logic [YW-1:0] addr;
    logic [XS-1:0] data;
    logic          done;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   tdata = '0;
  logic [3:0]    tkeep = 4'hF;
  logic          tlast = 1'b0;
  logic          tuser = 1'b0;
  logic          tvalid = 1'b0;
  logic          tready;
  logic [XS-1:0] line_wdata;
  logic [YW-1:0] line_waddr;
  logic          line_we;
  logic          frame_done;
  logic          sync_err;
  logic          err_clr = 1'b0;

  int   n_chk  = 0;
  int   n_fail = 0;
  bit   rdy_chk = 1'b0;
  exp_t exp_q[$];
  logic [23:0] pix [XS];

  cell_frame_capture #(.X_SIZE(XS), .Y_SIZE(YS)) dut (
    .in_stream_aclk(clk), .periph_reset(rst),
    .in_stream_tdata(tdata), .in_stream_tkeep(tkeep), .in_stream_tlast(tlast),
    .in_stream_tuser(tuser), .in_stream_tvalid(tvalid), .in_stream_tready(tready),
    .line_wdata(line_wdata), .line_waddr(line_waddr), .line_we(line_we),
    .frame_done(frame_done), .sync_err(sync_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  function automatic logic live_px(input logic [23:0] px);
`ifdef CELL_CAPTURE_COLOUR_MATCH_EN
    return px == 24'hCB416B;
`else
    return px != 24'h0;
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (line_we) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {32'd0, 4'd0, 1'b0, line_waddr, line_wdata}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("line_waddr", 64'(line_waddr), 64'(e.addr));
          chk("line_wdata", 64'(line_wdata), 64'(e.data));
          chk("frame_done", 64'(frame_done), 64'(e.done));
        end
      end else if (frame_done) begin
        chk("stray_frame_done", 64'(frame_done), 64'd0);
      end
      if (rdy_chk) chk("tready_vs_commit", 64'(tready), 64'(!line_we));
    end
  end

  task automatic set_pattern(input int p);
    for (int x = 0; x < XS; x++) pix[x] = 24'h0;
    case (p)
      0: pix[0] = 24'hCB416B;
      1: begin pix[1] = 24'h000001; pix[2] = 24'h000001; pix[3] = 24'h000001; end
      2: for (int x = 0; x < XS; x++) pix[x] = 24'hCB416B;
      3: for (int x = 0; x < XS; x += 2) pix[x] = 24'h010000;
      4: begin pix[4] = 24'hCB416B; pix[6] = 24'hCB416A; pix[7] = 24'hCB416B; pix[15] = 24'h0000FF; end
      5: begin for (int x = 8; x < 12; x++) pix[x] = 24'hCB416B; pix[12] = 24'h000100; end
      6: begin for (int x = 1; x < XS; x += 2) pix[x] = 24'hCB416B; pix[14] = 24'h100000; end
      default: begin pix[2] = 24'hCB416B; pix[3] = 24'hCB416B; pix[13] = 24'hFFFFFF; end
    endcase
  endtask

  task automatic push_row(input int y, input bit done);
    exp_t e;
    e.addr = YW'(y);
    e.done = done;
    for (int x = 0; x < XS; x++) e.data[XS-1-x] = live_px(pix[x]);
    exp_q.push_back(e);
  endtask

  task automatic send_beat(input logic [31:0] d, input bit u, input bit l);
    bit hs;
    tdata = d; tuser = u; tlast = l; tvalid = 1'b1;
    for (int t = 0; t < 20; t++) begin
      hs = tready;
      @(posedge clk); #1;
      if (hs) begin
        tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0;
        return;
      end
    end
    chk("handshake_timeout", 64'(tready), 64'd1);
    tvalid = 1'b0;
  endtask

  task automatic send_row(input int nbeats, input int user_at, input int last_at, input bit stall);
    logic [7:0] bytes [XS*3];
    for (int x = 0; x < XS; x++) begin
      bytes[3*x]   = pix[x][23:16];
      bytes[3*x+1] = pix[x][15:8];
      bytes[3*x+2] = pix[x][7:0];
    end
    for (int j = 0; j < nbeats; j++) begin
      if (stall && $urandom_range(0, 2) == 0) begin
        tvalid = 1'b0;
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
      send_beat({bytes[4*j+3], bytes[4*j+2], bytes[4*j+1], bytes[4*j]}, j == user_at, j == last_at);
    end
  endtask

  task automatic send_rows(input int y0, input int y1, input int pat, input bit stall);
    for (int y = y0; y <= y1; y++) begin
      set_pattern(pat < 0 ? y : pat);
      push_row(y, y == YS - 1);
      send_row(WORDS, (y == 0) ? 0 : -1, WORDS - 1, stall);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tready", 64'(tready), 64'd0);
    chk("rst_line_we", 64'(line_we), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_sync_err", 64'(sync_err), 64'd0);
    chk("rst_line_wdata", 64'(line_wdata), 64'd0);
    chk("rst_line_waddr", 64'(line_waddr), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("tready_after_reset", 64'(tready), 64'd1);
    rdy_chk = 1'b1;

    // clean frame, then every pattern (incl. straddling pixels) with stalls
    send_rows(0, YS - 1, 0, 1'b0);
    chk("clean_sync_err", 64'(sync_err), 64'd0);
    send_rows(0, YS - 1, -1, 1'b1);
    chk("pattern_sync_err", 64'(sync_err), 64'd0);

    // early tlast on row 3
    send_rows(0, 2, 0, 1'b0);
    set_pattern(0);
    send_row(6, -1, 5, 1'b0);
    chk("early_tlast_err", 64'(sync_err), 64'd1);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("err_clr", 64'(sync_err), 64'd0);
    send_row(WORDS, -1, WORDS - 1, 1'b0);
    send_rows(0, YS - 1, -1, 1'b0);
    chk("recover_sync_err", 64'(sync_err), 64'd0);

    // SOF in the middle of row 5 restarts at row 0
    send_rows(0, 4, 3, 1'b0);
    set_pattern(7);
    send_row(3, -1, -1, 1'b0);
    push_row(0, 1'b0);
    send_row(WORDS, 0, WORDS - 1, 1'b0);
    chk("midsof_err", 64'(sync_err), 64'd1);
    send_rows(1, YS - 1, 0, 1'b0);

    // reset in the middle of row 2
    send_rows(0, 1, 2, 1'b0);
    set_pattern(0);
    send_row(5, -1, -1, 1'b0);
    rdy_chk = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_line_wdata", 64'(line_wdata), 64'd0);
    chk("midrst_line_waddr", 64'(line_waddr), 64'd0);
    chk("midrst_sync_err", 64'(sync_err), 64'd0);
    chk("midrst_tready", 64'(tready), 64'd0);
    chk("midrst_pending", 64'(exp_q.size()), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    rdy_chk = 1'b1;
    send_rows(0, YS - 1, 0, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    chk("final_pending", 64'(exp_q.size()), 64'd0);
    chk("final_sync_err", 64'(sync_err), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
